// File: rtl/microwave_timer_pkg.sv
// Shared types for the microwave cook-time countdown: FSM states,
// BCD mm:ss time word, and the load-validity check.
package microwave_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    RUNNING = 3'd2,
    PAUSED  = 3'd3,
    DONE    = 3'd4
  } timer_state_t;

  typedef logic [3:0] bcd_t;

  // Digit order matches the keypad/display word: {min_tens, min_ones, sec_tens, sec_ones}
  typedef struct packed {
    bcd_t min_tens;
    bcd_t min_ones;
    bcd_t sec_tens;
    bcd_t sec_ones;
  } mmss_t;

  localparam mmss_t MMSS_ZERO = 16'h0000;
  localparam mmss_t MMSS_ONE  = 16'h0001;

  // A keypad time is usable only if every digit is decimal and seconds stay below 60
  function automatic logic mmss_valid(mmss_t t);
    return (t.min_tens <= 4'd9) && (t.min_ones <= 4'd9) &&
           (t.sec_tens <= 4'd5) && (t.sec_ones <= 4'd9);
  endfunction

endpackage

// File: rtl/microwave_timer_if.sv
// Controller <-> timer signal bundle. The controller side is the master.
interface microwave_timer_if;
  logic        run;
  logic        load;
  logic        clear;
  logic [15:0] time_in;
  logic        finish;
  logic        busy;
  logic        load_err;
  logic [15:0] time_out;

  modport master (output run, load, clear, time_in,
                  input  finish, busy, load_err, time_out);
  modport slave  (input  run, load, clear, time_in,
                  output finish, busy, load_err, time_out);
endinterface

// File: rtl/microwave_timer_bcd_dec.sv
// Combinational one-second decrement of a BCD mm:ss value.
// Saturates at 00:00 so the countdown can never wrap to 99:59.
module mmss_bcd_dec
  import microwave_pkg::*;
(
  input  mmss_t i_time,
  output mmss_t o_time
);

  logic w_zero;
  logic w_b0;   // borrow out of sec_ones
  logic w_b1;   // borrow out of sec_tens
  logic w_b2;   // borrow out of min_ones

  assign w_zero = (i_time == MMSS_ZERO);
  assign w_b0   = (i_time.sec_ones == 4'd0);
  assign w_b1   = w_b0 && (i_time.sec_tens == 4'd0);
  assign w_b2   = w_b1 && (i_time.min_ones == 4'd0);

  // Ripple the borrow from seconds-ones up to minutes-tens
  always_comb begin
    o_time = i_time;
    if (!w_zero) begin
      o_time.sec_ones = w_b0 ? 4'd9 : i_time.sec_ones - 4'd1;
      if (w_b0) o_time.sec_tens = (i_time.sec_tens == 4'd0) ? 4'd5 : i_time.sec_tens - 4'd1;
      if (w_b1) o_time.min_ones = (i_time.min_ones == 4'd0) ? 4'd9 : i_time.min_ones - 4'd1;
      if (w_b2) o_time.min_tens = i_time.min_tens - 4'd1;
    end
  end

endmodule

// File: rtl/microwave_timer.sv
// Cook-time countdown. Counts the loaded mm:ss down one second per
// CLK_DIV cycles while run (controller heat) is high; finish holds
// in DONE until a new load or clear.
module microwave_timer
  import microwave_pkg::*;
#(
  parameter int CLK_DIV = 1000
) (
  input  logic             clk,
  input  logic             nrst,
  microwave_timer_if.slave bus
);

  localparam int             PW      = $clog2(CLK_DIV);
  localparam logic [PW-1:0]  PS_LAST = PW'(CLK_DIV - 1);

  timer_state_t  r_state;
  mmss_t         r_time;
  logic [PW-1:0] r_presc;
  logic          r_finish;
  logic          r_busy;
  logic          r_load_err;

  mmss_t w_time_in;
  mmss_t w_time_dec;
  logic  w_load_ok;
  logic  w_load_zero;
  logic  w_tick;
  logic  w_last;

  assign w_time_in   = mmss_t'(bus.time_in);
  assign w_load_ok   = mmss_valid(w_time_in);
  assign w_load_zero = (w_time_in == MMSS_ZERO);
  assign w_tick      = (r_presc == PS_LAST);
  // 00:00 is included so a zero time armed from ARMED/PAUSED still terminates
  assign w_last      = (r_time == MMSS_ONE) || (r_time == MMSS_ZERO);

  mmss_bcd_dec u_dec (
    .i_time (r_time),
    .o_time (w_time_dec)
  );

  // Timer FSM: clear beats load beats run/tick; outputs registered alongside state
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state    <= IDLE;
      r_time     <= MMSS_ZERO;
      r_presc    <= '0;
      r_finish   <= 1'b0;
      r_busy     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_load_err <= 1'b0;
      if (bus.clear) begin
        r_state  <= IDLE;
        r_time   <= MMSS_ZERO;
        r_presc  <= '0;
        r_finish <= 1'b0;
        r_busy   <= 1'b0;
      end else if (bus.load && (r_state != RUNNING)) begin
        if (!w_load_ok) begin
          r_load_err <= 1'b1;
        end else begin
          r_time   <= w_time_in;
          r_presc  <= '0;
          r_finish <= 1'b0;
          r_busy   <= 1'b0;
          // A zero time only parks the timer from IDLE/DONE; ARMED/PAUSED always re-arm
          if (w_load_zero && ((r_state == IDLE) || (r_state == DONE))) r_state <= IDLE;
          else                                                         r_state <= ARMED;
        end
      end else begin
        // Loads during RUNNING land here and are silently ignored
        case (r_state)
          IDLE: if (bus.run) begin
            // Heating with no time set ends immediately
            r_state  <= DONE;
            r_finish <= 1'b1;
          end
          ARMED: if (bus.run) begin
            r_state <= RUNNING;
            r_busy  <= 1'b1;
          end
          RUNNING: begin
            if (!bus.run) begin
              // Prescaler held so the partial second survives the pause
              r_state <= PAUSED;
              r_busy  <= 1'b0;
            end else if (w_tick) begin
              r_presc <= '0;
              if (w_last) begin
                r_state  <= DONE;
                r_time   <= MMSS_ZERO;
                r_busy   <= 1'b0;
                r_finish <= 1'b1;
              end else begin
                r_time <= w_time_dec;
              end
            end else begin
              r_presc <= r_presc + PW'(1);
            end
          end
          PAUSED: if (bus.run) begin
            r_state <= RUNNING;
            r_busy  <= 1'b1;
          end
          DONE: ;
          default: begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_finish <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.time_out = r_time;
  assign bus.finish   = r_finish;
  assign bus.busy     = r_busy;
  assign bus.load_err = r_load_err;

endmodule

// File: tb/tb_microwave_timer.sv
// Directed bench for microwave_timer at CLK_DIV=4, plus standalone
// vectors for the BCD decrementer.
module tb_microwave_timer;
  import microwave_pkg::*;

  logic clk;
  logic nrst;
  int   n_checks;
  int   n_errors;

  microwave_timer_if bus ();

  microwave_timer #(.CLK_DIV(4)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  mmss_t dec_in;
  mmss_t dec_out;
  mmss_bcd_dec u_dec_tb (.i_time(dec_in), .o_time(dec_out));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    bus.load    = 1'b1;
    bus.time_in = v;
    tick();
    bus.load    = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    #3;
    n_checks++;
    if ({bus.finish, bus.busy, bus.load_err, bus.time_out} !== 19'h0) begin
      n_errors++;
      $display("FAIL reset_outputs got f=%b b=%b e=%b t=%h exp all 0",
               bus.finish, bus.busy, bus.load_err, bus.time_out);
    end
    tick();
    nrst = 1'b1;
    tick();
  endtask

  task automatic test_countdown();
    do_load(16'h0003);
    n_checks++;
    if (bus.time_out !== 16'h0003 || bus.busy !== 1'b0) begin
      n_errors++; $display("FAIL cd_armed got t=%h b=%b exp 0003 0", bus.time_out, bus.busy);
    end
    bus.run = 1'b1;
    tick();                       // edge 0
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_errors++; $display("FAIL cd_busy_e0 got %b exp 1", bus.busy);
    end
    repeat (4) tick();            // edge 4
    n_checks++;
    if (bus.time_out !== 16'h0002) begin
      n_errors++; $display("FAIL cd_e4 got %h exp 0002", bus.time_out);
    end
    repeat (4) tick();            // edge 8
    n_checks++;
    if (bus.time_out !== 16'h0001) begin
      n_errors++; $display("FAIL cd_e8 got %h exp 0001", bus.time_out);
    end
    repeat (3) tick();            // edge 11
    n_checks++;
    if (bus.finish !== 1'b0) begin
      n_errors++; $display("FAIL cd_e11_finish got %b exp 0", bus.finish);
    end
    tick();                       // edge 12
    n_checks++;
    if (bus.finish !== 1'b1 || bus.time_out !== 16'h0000 || bus.busy !== 1'b0) begin
      n_errors++; $display("FAIL cd_e12 got f=%b t=%h b=%b exp 1 0000 0",
                           bus.finish, bus.time_out, bus.busy);
    end
    bus.run = 1'b0;
    repeat (2) tick();
    n_checks++;
    if (bus.finish !== 1'b1) begin
      n_errors++; $display("FAIL cd_finish_hold got %b exp 1", bus.finish);
    end
  endtask

  task automatic test_borrow();
    do_load(16'h0100);            // from DONE -> ARMED
    bus.run = 1'b1;
    repeat (5) tick();            // edges 0..4
    n_checks++;
    if (bus.time_out !== 16'h0059) begin
      n_errors++; $display("FAIL br_0100 got %h exp 0059", bus.time_out);
    end
    bus.run = 1'b0;
    tick();                       // -> PAUSED
    do_load(16'h1000);            // PAUSED -> ARMED
    n_checks++;
    if (bus.time_out !== 16'h1000 || bus.busy !== 1'b0) begin
      n_errors++; $display("FAIL br_reload got t=%h b=%b exp 1000 0", bus.time_out, bus.busy);
    end
    bus.run = 1'b1;
    repeat (5) tick();
    n_checks++;
    if (bus.time_out !== 16'h0959) begin
      n_errors++; $display("FAIL br_1000 got %h exp 0959", bus.time_out);
    end
    bus.run = 1'b0;
    do_clear();
  endtask

  task automatic test_pause();
    do_load(16'h0002);
    bus.run = 1'b1;
    repeat (7) tick();            // edges 0..6: one decrement, prescaler at 2
    n_checks++;
    if (bus.time_out !== 16'h0001 || bus.busy !== 1'b1) begin
      n_errors++; $display("FAIL pz_running got t=%h b=%b exp 0001 1", bus.time_out, bus.busy);
    end
    bus.run = 1'b0;
    repeat (10) tick();
    n_checks++;
    if (bus.time_out !== 16'h0001 || bus.busy !== 1'b0 || bus.finish !== 1'b0) begin
      n_errors++; $display("FAIL pz_held got t=%h b=%b f=%b exp 0001 0 0",
                           bus.time_out, bus.busy, bus.finish);
    end
    bus.run = 1'b1;
    tick();                       // resume edge, prescaler still 2
    n_checks++;
    if (bus.busy !== 1'b1 || bus.finish !== 1'b0) begin
      n_errors++; $display("FAIL pz_resume got b=%b f=%b exp 1 0", bus.busy, bus.finish);
    end
    tick();                       // prescaler 3
    n_checks++;
    if (bus.finish !== 1'b0) begin
      n_errors++; $display("FAIL pz_r1 got %b exp 0", bus.finish);
    end
    tick();                       // wrap from 00:01 -> DONE
    n_checks++;
    if (bus.finish !== 1'b1 || bus.time_out !== 16'h0000) begin
      n_errors++; $display("FAIL pz_r2 got f=%b t=%h exp 1 0000", bus.finish, bus.time_out);
    end
    bus.run = 1'b0;
    do_clear();
  endtask

  task automatic test_load_err();
    do_load(16'h0075);
    n_checks++;
    if (bus.load_err !== 1'b1 || bus.time_out !== 16'h0000) begin
      n_errors++; $display("FAIL le_0075 got e=%b t=%h exp 1 0000", bus.load_err, bus.time_out);
    end
    tick();
    n_checks++;
    if (bus.load_err !== 1'b0) begin
      n_errors++; $display("FAIL le_pulse_width got %b exp 0", bus.load_err);
    end
    do_load(16'h00A0);
    n_checks++;
    if (bus.load_err !== 1'b1 || bus.time_out !== 16'h0000) begin
      n_errors++; $display("FAIL le_00A0 got e=%b t=%h exp 1 0000", bus.load_err, bus.time_out);
    end
    // Still IDLE: run with no time goes straight to DONE
    bus.run = 1'b1;
    tick();
    n_checks++;
    if (bus.load_err !== 1'b0 || bus.finish !== 1'b1 || bus.busy !== 1'b0) begin
      n_errors++; $display("FAIL le_still_idle got e=%b f=%b b=%b exp 0 1 0",
                           bus.load_err, bus.finish, bus.busy);
    end
    bus.run = 1'b0;
    do_load(16'h0005);
    bus.run = 1'b1;
    tick();                       // RUNNING
    do_load(16'h0030);
    n_checks++;
    if (bus.load_err !== 1'b0 || bus.time_out !== 16'h0005 || bus.busy !== 1'b1) begin
      n_errors++; $display("FAIL le_run_ignore got e=%b t=%h b=%b exp 0 0005 1",
                           bus.load_err, bus.time_out, bus.busy);
    end
    bus.run = 1'b0;
    do_clear();
  endtask

  task automatic test_idle_run();
    bus.run = 1'b1;
    tick();
    n_checks++;
    if (bus.finish !== 1'b1 || bus.busy !== 1'b0) begin
      n_errors++; $display("FAIL ir_done got f=%b b=%b exp 1 0", bus.finish, bus.busy);
    end
    bus.run = 1'b0;
    do_load(16'h0010);
    n_checks++;
    if (bus.finish !== 1'b0 || bus.time_out !== 16'h0010 || bus.busy !== 1'b0) begin
      n_errors++; $display("FAIL ir_reload got f=%b t=%h b=%b exp 0 0010 0",
                           bus.finish, bus.time_out, bus.busy);
    end
    bus.run = 1'b1;
    tick();                       // ARMED -> RUNNING confirms ARMED
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_errors++; $display("FAIL ir_armed got b=%b exp 1", bus.busy);
    end
    bus.run = 1'b0;
    do_clear();
  endtask

  task automatic test_clear_reset();
    do_load(16'h0030);
    bus.run = 1'b1;
    repeat (2) tick();
    bus.clear   = 1'b1;
    bus.load    = 1'b1;
    bus.time_in = 16'h0045;
    tick();
    bus.clear = 1'b0;
    bus.load  = 1'b0;
    n_checks++;
    if (bus.time_out !== 16'h0000 || bus.busy !== 1'b0 || bus.finish !== 1'b0) begin
      n_errors++; $display("FAIL cl_clear_load got t=%h b=%b f=%b exp 0000 0 0",
                           bus.time_out, bus.busy, bus.finish);
    end
    bus.run = 1'b0;
    tick();
    do_load(16'h0030);
    bus.run = 1'b1;
    repeat (6) tick();
    #2 nrst = 1'b0;
    #1;
    n_checks++;
    if ({bus.finish, bus.busy, bus.load_err, bus.time_out} !== 19'h0) begin
      n_errors++; $display("FAIL cl_async_reset got f=%b b=%b e=%b t=%h exp all 0",
                           bus.finish, bus.busy, bus.load_err, bus.time_out);
    end
    bus.run = 1'b0;
    tick();
    nrst = 1'b1;
    tick();
  endtask

  task automatic test_dec();
    logic [15:0] din  [7];
    logic [15:0] dexp [7];
    din  = '{16'h1000, 16'h0000, 16'h9959, 16'h0100, 16'h2000, 16'h0010, 16'h0001};
    dexp = '{16'h0959, 16'h0000, 16'h9958, 16'h0059, 16'h1959, 16'h0009, 16'h0000};
    for (int i = 0; i < 7; i++) begin
      dec_in = mmss_t'(din[i]);
      #1;
      n_checks++;
      if (dec_out !== mmss_t'(dexp[i])) begin
        n_errors++; $display("FAIL dec_%h got %h exp %h", din[i], dec_out, dexp[i]);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    nrst        = 1'b1;
    bus.run     = 1'b0;
    bus.load    = 1'b0;
    bus.clear   = 1'b0;
    bus.time_in = 16'h0000;
    dec_in      = MMSS_ZERO;
    test_reset();
    test_countdown();
    test_borrow();
    test_pause();
    test_load_err();
    test_idle_run();
    test_clear_reset();
    test_dec();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
